// File: rtl/sdp_rd_arb_if.sv
// Bundle of the two SDP read clients and the shared MCIF read port seen by sdp_rd_arb.
// slave is the arbiter's view; master is the view of everything around it.
interface sdp_rd_arb_if #(
  parameter int REQ_PW = 47,
  parameter int RSP_PW = 65,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              c0_rd_req_valid;
  logic              c0_rd_req_ready;
  logic [REQ_PW-1:0] c0_rd_req_pd;
  logic              c1_rd_req_valid;
  logic              c1_rd_req_ready;
  logic [REQ_PW-1:0] c1_rd_req_pd;

  logic              arb2mcif_rd_req_valid;
  logic              arb2mcif_rd_req_ready;
  logic [REQ_PW-1:0] arb2mcif_rd_req_pd;

  logic              mcif2arb_rd_rsp_valid;
  logic              mcif2arb_rd_rsp_ready;
  logic [RSP_PW-1:0] mcif2arb_rd_rsp_pd;

  logic              c0_rd_rsp_valid;
  logic              c0_rd_rsp_ready;
  logic [RSP_PW-1:0] c0_rd_rsp_pd;
  logic              c1_rd_rsp_valid;
  logic              c1_rd_rsp_ready;
  logic [RSP_PW-1:0] c1_rd_rsp_pd;

  logic              arb2mcif_rd_cdt_lat_fifo_pop;
  logic [CNT_W-1:0]  outstanding_cnt;

  modport slave (
    input  c0_rd_req_valid, c0_rd_req_pd, c1_rd_req_valid, c1_rd_req_pd,
    output c0_rd_req_ready, c1_rd_req_ready,
    output arb2mcif_rd_req_valid, arb2mcif_rd_req_pd,
    input  arb2mcif_rd_req_ready,
    input  mcif2arb_rd_rsp_valid, mcif2arb_rd_rsp_pd,
    output mcif2arb_rd_rsp_ready,
    output c0_rd_rsp_valid, c0_rd_rsp_pd, c1_rd_rsp_valid, c1_rd_rsp_pd,
    input  c0_rd_rsp_ready, c1_rd_rsp_ready,
    output arb2mcif_rd_cdt_lat_fifo_pop, outstanding_cnt
  );

  modport master (
    output c0_rd_req_valid, c0_rd_req_pd, c1_rd_req_valid, c1_rd_req_pd,
    input  c0_rd_req_ready, c1_rd_req_ready,
    input  arb2mcif_rd_req_valid, arb2mcif_rd_req_pd,
    output arb2mcif_rd_req_ready,
    output mcif2arb_rd_rsp_valid, mcif2arb_rd_rsp_pd,
    input  mcif2arb_rd_rsp_ready,
    input  c0_rd_rsp_valid, c0_rd_rsp_pd, c1_rd_rsp_valid, c1_rd_rsp_pd,
    output c0_rd_rsp_ready, c1_rd_rsp_ready,
    input  arb2mcif_rd_cdt_lat_fifo_pop, outstanding_cnt
  );
endinterface

// File: rtl/sdp_rd_arb.sv
// Round-robin merge of the mrdma (client 0) and brdma (client 1) read streams onto one MCIF
// read port; an in-order tag FIFO steers response beats back to the issuing client.
module sdp_rd_arb #(
  parameter int REQ_PW = 47,
  parameter int RSP_PW = 65,
  parameter int DEPTH  = 8
) (
  input  logic         nvdla_core_clk,
  input  logic         nvdla_core_rst,
  sdp_rd_arb_if.slave  bus
);
  // All handshakes are valid/ready: a transfer happens on a rising clock edge where both
  // valid and ready are 1; a source holds valid and pd stable until that transfer.
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SZ_W  = 15;

  typedef struct packed {
    logic            id;
    logic [SZ_W-1:0] size;
  } tag_t;

  logic              out_valid_q, out_valid_d;
  logic [REQ_PW-1:0] out_pd_q, out_pd_d;
  logic              last_c1_q, last_c1_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SZ_W-1:0]   beat_cnt_q, beat_cnt_d;
  tag_t              tag_mem_q [DEPTH];

  logic              free, can_issue, grant0, grant1, push, pop;
  logic              not_empty, head_ready, beat_acc;
  tag_t              head;
  logic [REQ_PW-1:0] grant_pd;

  assign free      = !out_valid_q | bus.arb2mcif_rd_req_ready;
  // Only the registered count gates issue, so a pop never unblocks a push in the same cycle.
  assign can_issue = free & (cnt_q < CNT_W'(DEPTH));
  assign grant0    = bus.c0_rd_req_valid & (!bus.c1_rd_req_valid | last_c1_q);
  assign grant1    = bus.c1_rd_req_valid & (!bus.c0_rd_req_valid | !last_c1_q);
  assign push      = can_issue & (grant0 | grant1);
  assign grant_pd  = grant1 ? bus.c1_rd_req_pd : bus.c0_rd_req_pd;

  assign head       = tag_mem_q[rd_ptr_q];
  assign not_empty  = (cnt_q != '0);
  assign head_ready = head.id ? bus.c1_rd_rsp_ready : bus.c0_rd_rsp_ready;
  assign beat_acc   = bus.mcif2arb_rd_rsp_valid & bus.mcif2arb_rd_rsp_ready;
  assign pop        = beat_acc & (beat_cnt_q == head.size);

  assign bus.c0_rd_req_ready       = can_issue & grant0;
  assign bus.c1_rd_req_ready       = can_issue & grant1;
  assign bus.arb2mcif_rd_req_valid = out_valid_q;
  assign bus.arb2mcif_rd_req_pd    = out_pd_q;

  // An empty FIFO withholds ready so a stray beat stalls instead of being dropped.
  assign bus.mcif2arb_rd_rsp_ready = not_empty & head_ready;
  assign bus.c0_rd_rsp_valid = bus.mcif2arb_rd_rsp_valid & not_empty & (head.id == 1'b0);
  assign bus.c1_rd_rsp_valid = bus.mcif2arb_rd_rsp_valid & not_empty & (head.id == 1'b1);
  assign bus.c0_rd_rsp_pd    = bus.mcif2arb_rd_rsp_pd;
  assign bus.c1_rd_rsp_pd    = bus.mcif2arb_rd_rsp_pd;
  assign bus.arb2mcif_rd_cdt_lat_fifo_pop = beat_acc;
  assign bus.outstanding_cnt = cnt_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_pd_d    = out_pd_q;
    last_c1_d   = last_c1_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    beat_cnt_d  = beat_cnt_q;

    if (push) begin
      out_valid_d = 1'b1;
      out_pd_d    = grant_pd;
      last_c1_d   = grant1;
      wr_ptr_d    = wr_ptr_q + PTR_W'(1);
    end else if (bus.arb2mcif_rd_req_ready) begin
      out_valid_d = 1'b0;
    end

    if (beat_acc) begin
      if (pop) begin
        beat_cnt_d = '0;
        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      end else begin
        beat_cnt_d = beat_cnt_q + SZ_W'(1);
      end
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // last_c1 resets to 1 so client 0 wins the first contended grant.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      out_valid_q <= 1'b0;
      out_pd_q    <= '0;
      last_c1_q   <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      beat_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_pd_q    <= out_pd_d;
      last_c1_q   <= last_c1_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (push) begin
      tag_mem_q[wr_ptr_q] <= '{id: grant1, size: grant_pd[32 +: SZ_W]};
    end
  end
endmodule

// File: tb/tb_sdp_rd_arb.sv
// Directed bench for sdp_rd_arb: arbitration order, backpressure, tag FIFO full, in-order
// response routing and asynchronous reset, each checked against hand-computed values.
module tb_sdp_rd_arb;
  localparam int REQ_PW = 47;
  localparam int RSP_PW = 65;
  localparam int DEPTH  = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [REQ_PW-1:0] exp_q[$];
  logic [REQ_PW-1:0] req_a, req_b, req_c, req_d;
  logic [RSP_PW-1:0] beat;

  sdp_rd_arb_if #(.REQ_PW(REQ_PW), .RSP_PW(RSP_PW), .DEPTH(DEPTH)) bus ();

  sdp_rd_arb #(.REQ_PW(REQ_PW), .RSP_PW(RSP_PW), .DEPTH(DEPTH)) u_dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [REQ_PW-1:0] mk_req(input logic [14:0] sz, input logic [31:0] addr);
    return {sz, addr};
  endfunction

  // An accepted beat with no outstanding request must never happen.
  always @(negedge clk) begin
    if (n_checks > 0)
      check("no_stray_accept",
            bus.mcif2arb_rd_rsp_valid & bus.mcif2arb_rd_rsp_ready & (bus.outstanding_cnt == 0), 0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.c0_rd_req_valid = 1'b0; bus.c0_rd_req_pd = '0;
    bus.c1_rd_req_valid = 1'b0; bus.c1_rd_req_pd = '0;
    bus.arb2mcif_rd_req_ready = 1'b1;
    bus.mcif2arb_rd_rsp_valid = 1'b0; bus.mcif2arb_rd_rsp_pd = '0;
    bus.c0_rd_rsp_ready = 1'b1; bus.c1_rd_rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_arb_valid", bus.arb2mcif_rd_req_valid, 0);
    check("rst_arb_pd", bus.arb2mcif_rd_req_pd, 0);
    check("rst_cnt", bus.outstanding_cnt, 0);
    check("rst_rsp_ready", bus.mcif2arb_rd_rsp_ready, 0);
    check("rst_c0_rsp_valid", bus.c0_rd_rsp_valid, 0);
    check("rst_cdt_pop", bus.arb2mcif_rd_cdt_lat_fifo_pop, 0);

    // Contention: alternate c0,c1,c0,c1 from reset, one grant per cycle.
    tick();
    req_a = mk_req(15'd0, 32'h0000_2000);
    req_b = mk_req(15'd0, 32'h0000_3000);
    bus.c0_rd_req_pd = req_a; bus.c1_rd_req_pd = req_b;
    bus.c0_rd_req_valid = 1'b1; bus.c1_rd_req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("cont_c0_ready", bus.c0_rd_req_ready, (k % 2) == 0);
      check("cont_c1_ready", bus.c1_rd_req_ready, (k % 2) == 1);
      exp_q.push_back(((k % 2) == 0) ? req_a : req_b);
      tick();
      check("cont_arb_valid", bus.arb2mcif_rd_req_valid, 1);
      check("cont_arb_pd", bus.arb2mcif_rd_req_pd, exp_q.pop_front());
    end
    bus.c0_rd_req_valid = 1'b0; bus.c1_rd_req_valid = 1'b0;
    tick();
    check("cont_arb_idle", bus.arb2mcif_rd_req_valid, 0);
    check("cont_cnt", bus.outstanding_cnt, 4);
    bus.mcif2arb_rd_rsp_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("cont_rsp_c0", bus.c0_rd_rsp_valid, (k % 2) == 0);
      check("cont_rsp_c1", bus.c1_rd_rsp_valid, (k % 2) == 1);
      tick();
    end
    bus.mcif2arb_rd_rsp_valid = 1'b0;
    #1 check("cont_cnt_drained", bus.outstanding_cnt, 0);

    // Single c0 request of 4 beats.
    tick();
    req_a = mk_req(15'd3, 32'h0000_1000);
    bus.c0_rd_req_pd = req_a; bus.c0_rd_req_valid = 1'b1;
    #1;
    check("single_c0_ready", bus.c0_rd_req_ready, 1);
    check("single_c1_ready", bus.c1_rd_req_ready, 0);
    check("single_arb_pre", bus.arb2mcif_rd_req_valid, 0);
    tick();
    bus.c0_rd_req_valid = 1'b0;
    check("single_arb_valid", bus.arb2mcif_rd_req_valid, 1);
    check("single_arb_pd", bus.arb2mcif_rd_req_pd, req_a);
    check("single_cnt1", bus.outstanding_cnt, 1);
    tick();
    check("single_arb_done", bus.arb2mcif_rd_req_valid, 0);
    bus.mcif2arb_rd_rsp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      beat = {1'b1, 64'hA5A5_0000_0000_0000 + 64'(i)};
      bus.mcif2arb_rd_rsp_pd = beat;
      #1;
      check("single_rsp_c0", bus.c0_rd_rsp_valid, 1);
      check("single_rsp_c1", bus.c1_rd_rsp_valid, 0);
      check("single_rsp_ready", bus.mcif2arb_rd_rsp_ready, 1);
      check("single_rsp_pd", bus.c0_rd_rsp_pd, beat);
      check("single_pop", bus.arb2mcif_rd_cdt_lat_fifo_pop, 1);
      check("single_cnt_hold", bus.outstanding_cnt, 1);
      tick();
    end
    bus.mcif2arb_rd_rsp_valid = 1'b0;
    #1;
    check("single_cnt0", bus.outstanding_cnt, 0);
    check("single_pop_idle", bus.arb2mcif_rd_cdt_lat_fifo_pop, 0);

    // Backpressure on the shared port for 5 cycles.
    tick();
    req_c = mk_req(15'd0, 32'h0000_4000);
    req_d = mk_req(15'd0, 32'h0000_5000);
    bus.arb2mcif_rd_req_ready = 1'b0;
    bus.c0_rd_req_pd = req_c; bus.c0_rd_req_valid = 1'b1;
    #1 check("bp_first_ready", bus.c0_rd_req_ready, 1);
    exp_q.push_back(req_c);
    tick();
    bus.c0_rd_req_pd = req_d;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_no_grant", bus.c0_rd_req_ready, 0);
      check("bp_valid_hold", bus.arb2mcif_rd_req_valid, 1);
      check("bp_pd_hold", bus.arb2mcif_rd_req_pd, req_c);
      tick();
    end
    bus.arb2mcif_rd_req_ready = 1'b1;
    #1;
    check("bp_resume_ready", bus.c0_rd_req_ready, 1);
    check("bp_resume_pd", bus.arb2mcif_rd_req_pd, exp_q.pop_front());
    exp_q.push_back(req_d);
    tick();
    bus.c0_rd_req_valid = 1'b0;
    check("bp_second_valid", bus.arb2mcif_rd_req_valid, 1);
    check("bp_second_pd", bus.arb2mcif_rd_req_pd, exp_q.pop_front());
    tick();
    check("bp_idle", bus.arb2mcif_rd_req_valid, 0);
    check("bp_cnt", bus.outstanding_cnt, 2);
    bus.mcif2arb_rd_rsp_valid = 1'b1;
    repeat (2) begin
      #1 check("bp_rsp_c0", bus.c0_rd_rsp_valid, 1);
      tick();
    end
    bus.mcif2arb_rd_rsp_valid = 1'b0;
    #1 check("bp_cnt0", bus.outstanding_cnt, 0);

    // Fill the tag FIFO with 8 single-beat c1 requests.
    tick();
    bus.c1_rd_req_pd = mk_req(15'd0, 32'h0000_6000);
    bus.c1_rd_req_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1 check("full_fill_ready", bus.c1_rd_req_ready, 1);
      tick();
    end
    #1;
    check("full_stall", bus.c1_rd_req_ready, 0);
    check("full_cnt8", bus.outstanding_cnt, 8);
    tick();
    bus.mcif2arb_rd_rsp_valid = 1'b1;
    #1;
    check("full_same_cycle_stall", bus.c1_rd_req_ready, 0);
    check("full_pop_pulse", bus.arb2mcif_rd_cdt_lat_fifo_pop, 1);
    check("full_rsp_c1", bus.c1_rd_rsp_valid, 1);
    tick();
    bus.mcif2arb_rd_rsp_valid = 1'b0;
    #1;
    check("full_cnt7", bus.outstanding_cnt, 7);
    check("full_unblock", bus.c1_rd_req_ready, 1);
    tick();
    bus.c1_rd_req_valid = 1'b0;
    #1 check("full_cnt8_again", bus.outstanding_cnt, 8);
    bus.mcif2arb_rd_rsp_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1 check("full_drain_c1", bus.c1_rd_rsp_valid, 1);
      tick();
    end
    bus.mcif2arb_rd_rsp_valid = 1'b0;
    #1 check("full_cnt0", bus.outstanding_cnt, 0);

    // In-order routing: c1 (2 beats) blocks c0 (1 beat) while c1 stalls.
    tick();
    bus.c1_rd_req_pd = mk_req(15'd1, 32'h0000_7000);
    bus.c1_rd_req_valid = 1'b1;
    #1 check("ord_c1_grant", bus.c1_rd_req_ready, 1);
    tick();
    bus.c1_rd_req_valid = 1'b0;
    bus.c0_rd_req_pd = mk_req(15'd0, 32'h0000_8000);
    bus.c0_rd_req_valid = 1'b1;
    #1 check("ord_c0_grant", bus.c0_rd_req_ready, 1);
    tick();
    bus.c0_rd_req_valid = 1'b0;
    bus.c1_rd_rsp_ready = 1'b0;
    bus.mcif2arb_rd_rsp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ord_stall_ready", bus.mcif2arb_rd_rsp_ready, 0);
      check("ord_stall_c1", bus.c1_rd_rsp_valid, 1);
      check("ord_stall_c0", bus.c0_rd_rsp_valid, 0);
      check("ord_stall_pop", bus.arb2mcif_rd_cdt_lat_fifo_pop, 0);
      tick();
    end
    bus.c1_rd_rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("ord_c1_beat", bus.c1_rd_rsp_valid, 1);
      check("ord_c1_only", bus.c0_rd_rsp_valid, 0);
      check("ord_c1_ready", bus.mcif2arb_rd_rsp_ready, 1);
      tick();
    end
    #1;
    check("ord_c0_beat", bus.c0_rd_rsp_valid, 1);
    check("ord_c0_only", bus.c1_rd_rsp_valid, 0);
    tick();
    bus.mcif2arb_rd_rsp_valid = 1'b0;
    #1 check("ord_cnt0", bus.outstanding_cnt, 0);

    // A beat with nothing outstanding is stalled, not routed.
    tick();
    bus.mcif2arb_rd_rsp_valid = 1'b1;
    #1;
    check("stray_ready", bus.mcif2arb_rd_rsp_ready, 0);
    check("stray_c0", bus.c0_rd_rsp_valid, 0);
    check("stray_c1", bus.c1_rd_rsp_valid, 0);
    check("stray_pop", bus.arb2mcif_rd_cdt_lat_fifo_pop, 0);
    tick();
    bus.mcif2arb_rd_rsp_valid = 1'b0;
    check("stray_cnt", bus.outstanding_cnt, 0);

    // Asynchronous reset during beat 2 of a 4-beat c0 response.
    req_a = mk_req(15'd3, 32'h0000_9000);
    bus.c0_rd_req_pd = req_a; bus.c0_rd_req_valid = 1'b1;
    #1 check("rstm_grant", bus.c0_rd_req_ready, 1);
    tick();
    bus.c0_rd_req_valid = 1'b0;
    tick();
    bus.mcif2arb_rd_rsp_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1 check("rstm_beat", bus.c0_rd_rsp_valid, 1);
      tick();
    end
    #1 check("rstm_beat2", bus.c0_rd_rsp_valid, 1);
    rst = 1'b1;
    bus.c0_rd_req_valid = 1'b1; bus.c1_rd_req_valid = 1'b1;
    bus.c1_rd_req_pd = mk_req(15'd0, 32'h0000_A000);
    #1;
    check("rstm_c0_rsp_valid", bus.c0_rd_rsp_valid, 0);
    check("rstm_c1_rsp_valid", bus.c1_rd_rsp_valid, 0);
    check("rstm_rsp_ready", bus.mcif2arb_rd_rsp_ready, 0);
    check("rstm_arb_valid", bus.arb2mcif_rd_req_valid, 0);
    check("rstm_arb_pd", bus.arb2mcif_rd_req_pd, 0);
    check("rstm_cnt", bus.outstanding_cnt, 0);
    check("rstm_pop", bus.arb2mcif_rd_cdt_lat_fifo_pop, 0);
    bus.mcif2arb_rd_rsp_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("rstm_first_c0", bus.c0_rd_req_ready, 1);
    check("rstm_first_c1", bus.c1_rd_req_ready, 0);
    tick();
    bus.c0_rd_req_valid = 1'b0; bus.c1_rd_req_valid = 1'b0;
    check("rstm_post_valid", bus.arb2mcif_rd_req_valid, 1);
    check("rstm_post_pd", bus.arb2mcif_rd_req_pd, req_a);
    check("rstm_post_cnt", bus.outstanding_cnt, 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
